// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps a single request outstanding on
// the instruction bus, buffers one returned word for the IF/ID register, and
// handles delay-slot branches plus exception flushes (including dropping an
// in-flight fetch whose address cannot be withdrawn from the bus).
module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  // FETCH: waiting for our own request; VALID: holding an instruction;
  // DISCARD: waiting out a stale request after a flush.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    VALID   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_buf, inst_buf_nxt;
  logic [31:0] redirect_pc, redirect_pc_nxt;
  logic [31:0] next_addr;
  logic        consume;

  // Only the IF bit of the stall vector is relevant to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall[5:1];

  // The held instruction is the delay slot, so a taken branch steers the fetch after it.
  assign next_addr = branch_flag_i ? branch_target_address_i : pc + 32'd4;
  assign consume   = (state == VALID) && !stall[0];

  // State register with synchronous reset; a reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_ADDR;
      inst_buf    <= 32'd0;
      redirect_pc <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst_buf    <= inst_buf_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // Next-state logic; a flush beats consume/branch, but an unacked request must
  // keep its address on the bus, hence the detour through DISCARD.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inst_buf_nxt    = inst_buf;
    redirect_pc_nxt = redirect_pc;
    if (flush_i) begin
      case (state)
        FETCH, DISCARD: begin
          if (!inst_ack_i) begin
            redirect_pc_nxt = new_pc_i;
            state_nxt       = DISCARD;
          end else begin
            pc_nxt    = new_pc_i;
            state_nxt = FETCH;
          end
        end
        VALID: begin
          if (consume && !inst_ack_i) begin
            redirect_pc_nxt = new_pc_i;
            pc_nxt          = next_addr;
            state_nxt       = DISCARD;
          end else begin
            pc_nxt    = new_pc_i;
            state_nxt = FETCH;
          end
        end
        default: begin
          pc_nxt    = new_pc_i;
          state_nxt = FETCH;
        end
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (inst_ack_i) begin
            inst_buf_nxt = inst_data_i;
            state_nxt    = VALID;
          end
        end
        VALID: begin
          if (consume) begin
            pc_nxt = next_addr;
            if (inst_ack_i) begin
              inst_buf_nxt = inst_data_i;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
        DISCARD: begin
          if (inst_ack_i) begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Bus and pipeline outputs; everything is forced quiet while reset is held.
  always_comb begin
    inst_req_o  = 1'b0;
    inst_addr_o = 32'd0;
    if_pc       = 32'd0;
    if_inst     = 32'd0;
    stallreq_o  = 1'b0;
    if (!rst) begin
      case (state)
        FETCH, DISCARD: begin
          inst_req_o  = 1'b1;
          inst_addr_o = pc;
          stallreq_o  = 1'b1;
        end
        VALID: begin
          if_pc       = pc;
          if_inst     = inst_buf;
          inst_req_o  = consume;
          inst_addr_o = consume ? next_addr : 32'd0;
        end
        default: begin
          stallreq_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: a bus-slave memory with configurable wait states,
// an instruction-stream reference model feeding a scoreboard queue, and a
// monitor that checks every presented instruction against it.
module tb_if_fetch;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = 32'd0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = 32'd0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i = 1'b0;
  logic [31:0] inst_data_i = 32'd0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  int tests = 0;
  int fails = 0;
  int consumes = 0;

  // Memory slave state; mem_mode < 0 picks a random wait count per request.
  int          mem_mode = 0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_left = 0;

  // Reference model: PC of the next instruction the stage should hand over.
  logic [31:0] model_pc = RESET_ADDR;
  logic [31:0] exp_q[$];

  if_fetch #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .inst_req_o              (inst_req_o),
    .inst_addr_o             (inst_addr_o),
    .inst_ack_i              (inst_ack_i),
    .inst_data_i             (inst_data_i),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_o              (stallreq_o)
  );

  always #5 clk = ~clk;

  // Memory contents: scrambled address so instruction and PC differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock of stimulus: drive inputs at negedge, let memory answer at +1,
  // update the reference model at +3 (after the monitor has sampled at +2).
  task automatic applyStimulus(input bit r, input bit st, input bit br,
                               input logic [31:0] tgt, input bit fl,
                               input logic [31:0] npc);
    bit consumed;
    @(negedge clk);
    rst = r;
    stall = {5'd0, st};
    branch_flag_i = br;
    branch_target_address_i = tgt;
    flush_i = fl;
    new_pc_i = npc;
    #1;
    if (r) begin
      mem_busy = 1'b0;
      inst_ack_i = 1'b0;
      inst_data_i = 32'd0;
    end else if (inst_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = inst_addr_o;
        mem_left = (mem_mode < 0) ? int'($urandom_range(2, 0)) : mem_mode;
      end else begin
        checkOutput("bus_addr_stable", inst_addr_o, mem_addr);
      end
      if (mem_left == 0) begin
        inst_ack_i = 1'b1;
        inst_data_i = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        inst_ack_i = 1'b0;
        inst_data_i = $urandom;
        mem_left--;
      end
    end else begin
      if (mem_busy) begin
        checkOutput("bus_req_held", {31'd0, inst_req_o}, 32'd1);
        mem_busy = 1'b0;
      end
      inst_ack_i = ($urandom_range(3, 0) == 0);
      inst_data_i = $urandom;
    end
    consumed = !r && !fl && !st && !stallreq_o;
    #2;
    if (r) begin
      model_pc = RESET_ADDR;
      exp_q.delete();
      exp_q.push_back(model_pc);
    end else if (fl) begin
      model_pc = npc;
      exp_q.delete();
      exp_q.push_back(model_pc);
    end else if (consumed) begin
      model_pc = br ? tgt : model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
  endtask

  // Monitor: compares whatever the stage presents with the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        checkOutput("reset_outputs",
                    inst_addr_o | if_pc | if_inst | {30'd0, inst_req_o, stallreq_o}, 32'd0);
      end else if (stallreq_o) begin
        checkOutput("idle_if_pc", if_pc, 32'd0);
        checkOutput("idle_if_inst", if_inst, 32'd0);
        checkOutput("idle_req", {31'd0, inst_req_o}, 32'd1);
      end else if (exp_q.size() == 0) begin
        checkOutput("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q[0];
        checkOutput("if_pc", if_pc, e);
        checkOutput("if_inst", if_inst, mem_word(e));
        if (stall[0]) begin
          checkOutput("held_no_req", {31'd0, inst_req_o}, 32'd0);
        end else begin
          checkOutput("consume_req", {31'd0, inst_req_o}, 32'd1);
          checkOutput("consume_addr", inst_addr_o,
                      branch_flag_i ? branch_target_address_i : e + 32'd4);
          if (!flush_i) begin
            void'(exp_q.pop_front());
            consumes++;
          end
        end
      end
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int valid_cnt;
    int i;

    // Reset held for a few cycles: everything quiet.
    mem_mode = 0;
    repeat (3) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("rst_req", {31'd0, inst_req_o}, 32'd0);
    end

    // First request right after release, then one instruction per cycle.
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("first_req", {31'd0, inst_req_o}, 32'd1);
    checkOutput("first_addr", inst_addr_o, RESET_ADDR);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("zw_stallreq", {31'd0, stallreq_o}, 32'd0);
      checkOutput("zw_if_pc", if_pc, 32'(4 * (k - 1)));
    end

    // Two wait states: one instruction every three cycles.
    mem_mode = 2;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    valid_cnt = 0;
    repeat (9) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (!stallreq_o) valid_cnt++;
    end
    checkOutput("ws2_rate", 32'(valid_cnt), 32'd3);

    // Branch on a consume edge after two stalled cycles presenting 0x24.
    mem_mode = 0;
    applyStimulus(0, 1, 0, 0, 1, 32'h24);
    for (i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1, 32'h100, 0, 0);
      if (!stallreq_o) break;
    end
    checkOutput("wait_valid_24", {31'd0, stallreq_o}, 32'd0);
    checkOutput("stall1_pc", if_pc, 32'h24);
    checkOutput("stall1_req", {31'd0, inst_req_o}, 32'd0);
    applyStimulus(0, 1, 1, 32'h100, 0, 0);
    checkOutput("stall2_pc", if_pc, 32'h24);
    checkOutput("stall2_req", {31'd0, inst_req_o}, 32'd0);
    applyStimulus(0, 0, 1, 32'h100, 0, 0);
    checkOutput("branch_addr", inst_addr_o, 32'h100);

    // Flushes while the fetch of 0x40 is waiting; the last flush target wins.
    mem_mode = 3;
    applyStimulus(0, 1, 0, 0, 1, 32'h40);
    applyStimulus(0, 0, 0, 0, 1, 32'h180);
    checkOutput("flushA_addr", inst_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 1, 32'h200);
    checkOutput("flushB_addr", inst_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("discC_addr", inst_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("discD_ack", {31'd0, inst_ack_i}, 32'd1);
    checkOutput("discD_addr", inst_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("redirect_addr", inst_addr_o, 32'h200);

    // PC wrap-around from 0xFFFF_FFFC.
    mem_mode = 0;
    applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    for (i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (!stallreq_o) break;
    end
    checkOutput("wait_valid_wrap", {31'd0, stallreq_o}, 32'd0);
    checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("wrap_req", {31'd0, inst_req_o}, 32'd1);
    checkOutput("wrap_addr", inst_addr_o, 32'h0);

    // Reset in the middle of an outstanding request.
    mem_mode = 2;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_req", {31'd0, inst_req_o}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_req", {31'd0, inst_req_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart_req", {31'd0, inst_req_o}, 32'd1);
    checkOutput("restart_addr", inst_addr_o, RESET_ADDR);

    // Randomized traffic: stalls, branches, flushes, random wait states, rare resets.
    mem_mode = -1;
    repeat (1500) begin
      applyStimulus(($urandom_range(199, 0) == 0),
                    ($urandom_range(3, 0) == 0),
                    ($urandom_range(4, 0) == 0),
                    $urandom,
                    ($urandom_range(24, 0) == 0),
                    $urandom);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("min_consumes", {31'd0, (consumes >= 200)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
